// File: rtl/word_access_pkg.sv
// word_access_pkg
//   Shared types and constants for the word access scheduler:
//   - state_t : what the datapath is driven with in the current cycle
//   - op_t    : request operation (read / write)
//   - req_t   : a granted request {write, addr, wdata}
//   - NUM_WORDS, MAX_DATA_WIDTH : datapath geometry
//   - word_onehot() : word address to enable vector
package word_access_pkg;

  localparam int NUM_WORDS      = 2;
  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // wdata is sized for the widest supported word; narrower instances use the
  // low DATA_WIDTH bits.
  typedef struct packed {
    op_t                       write;
    logic                      addr;
    logic [MAX_DATA_WIDTH-1:0] wdata;
  } req_t;

  function automatic logic [NUM_WORDS-1:0] word_onehot(input logic addr);
    word_onehot       = '0;
    word_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/word_access_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at last_grant+1
//   (mod N) and picks the first eligible requester. The pointer register is
//   owned by the instantiating module.
//   Ports:
//     eligible   in  N      requesters allowed to win this cycle
//     last_grant in  IDX_W  index of the most recent transfer
//     grant      out N      one-hot or zero
//     grant_idx  out IDX_W  encoded winner (0 when no grant)
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!found && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_access_scheduler.sv
// word_access_scheduler
//   Arbitrating controller in front of a two-word register datapath.
//   Grants one request per cycle round-robin, drives the datapath enables
//   from registers and returns read data as a tagged response. A cycle with
//   a write enable is never followed by a cycle with a read enable.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     req_valid     in  NUM_REQ             request valid per requester
//     req_write     in  NUM_REQ             1 = write, 0 = read
//     req_addr      in  NUM_REQ             word select per requester
//     req_wdata     in  NUM_REQ*DATA_WIDTH  write data, slice i = requester i
//     req_ready     out NUM_REQ             combinational grant, one-hot/zero
//     rsp_valid     out NUM_REQ             one-hot read response strobe
//     rsp_rdata     out DATA_WIDTH          read response data
//     write_enable  out NUM_WORDS           datapath write strobe
//     read_enable   out NUM_WORDS           datapath read strobe
//     write_data    out DATA_WIDTH          datapath write data
//     read_data     in  DATA_WIDTH          datapath read data (same cycle)
module word_access_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [NUM_WORDS-1:0]          write_enable,
  output logic [NUM_WORDS-1:0]          read_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [DATA_WIDTH-1:0]         read_data
);

  import word_access_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                 state_q;
  state_t                 state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   rd_blocked;
  logic                   accept;
  req_t                   gnt_req;

  logic [NUM_WORDS-1:0]   we_p1;
  logic [NUM_WORDS-1:0]   re_p1;
  logic [DATA_WIDTH-1:0]  wdata_p1;
  logic [IDX_W-1:0]       tag_p1;
  logic                   vld_rd_p1;
  logic [NUM_REQ-1:0]     rsp_valid_p2;
  logic [DATA_WIDTH-1:0]  rsp_rdata_p2;

  // While a write is on the datapath, a waiting read forces one empty cycle
  // so the following cycle is IDLE and the read can win. Without this a
  // continuous write stream would starve reads forever.
  assign rd_blocked = (state_q == WRITE) && |(req_valid & ~req_write);

  always_comb begin
    eligible = req_valid;
    if (rd_blocked) begin
      eligible = '0;
    end else if (state_q == WRITE) begin
      eligible = req_valid & req_write;
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign accept    = |grant;
  assign req_ready = rst ? '0 : grant;

  always_comb begin
    gnt_req                        = '0;
    gnt_req.write                  = op_t'(req_write[grant_idx]);
    gnt_req.addr                   = req_addr[grant_idx];
    gnt_req.wdata[DATA_WIDTH-1:0]  = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = (gnt_req.write == OP_WRITE) ? WRITE : READ;
    end
  end

  // ---- Stage p1: datapath drive, state, pointer and in-flight tag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      we_p1        <= '0;
      re_p1        <= '0;
      wdata_p1     <= '0;
      tag_p1       <= '0;
      vld_rd_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_p1     <= '0;
      re_p1     <= '0;
      vld_rd_p1 <= 1'b0;
      if (accept) begin
        last_grant_q <= grant_idx;
        if (gnt_req.write == OP_WRITE) begin
          we_p1    <= word_onehot(gnt_req.addr);
          wdata_p1 <= gnt_req.wdata[DATA_WIDTH-1:0];
        end else begin
          re_p1     <= word_onehot(gnt_req.addr);
          tag_p1    <= grant_idx;
          vld_rd_p1 <= 1'b1;
        end
      end
    end
  end

  // ---- Stage p2: tagged read response ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_p2 <= '0;
      rsp_rdata_p2 <= '0;
    end else begin
      rsp_valid_p2 <= '0;
      if (vld_rd_p1) begin
        rsp_valid_p2 <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_p1;
        rsp_rdata_p2 <= read_data;
      end
    end
  end

  assign write_enable = we_p1;
  assign read_enable  = re_p1;
  assign write_data   = wdata_p1;
  assign rsp_valid    = rsp_valid_p2;
  assign rsp_rdata    = rsp_rdata_p2;

  a_we_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(write_enable));
  a_re_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(read_enable));
  a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_no_wr_then_rd: assert property (@(posedge clk) disable iff (rst)
    (|write_enable) |=> !(|read_enable));
  a_no_wr_and_rd: assert property (@(posedge clk) disable iff (rst)
    !((|write_enable) && (|read_enable)));

endmodule

// File: tb/tb_word_access_scheduler.sv
module tb_word_access_scheduler;
  import word_access_pkg::*;

  localparam int NR = 2;
  localparam int DW = 16;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR-1:0]    req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [NW-1:0]    write_enable;
  logic [NW-1:0]    read_enable;
  logic [DW-1:0]    write_data;
  logic [DW-1:0]    read_data;

  always #5 clk = ~clk;

  word_access_scheduler #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  // Two-word register datapath behind the scheduler.
  logic [DW-1:0] env_mem [NW] = '{'0, '0};
  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (write_enable[w]) env_mem[w] <= write_data;
    end
  end
  assign read_data = read_enable[1] ? env_mem[1] : (read_enable[0] ? env_mem[0] : '0);

  // Requester state: a request stays posted until the model sees it accepted.
  bit            pend_v [NR];
  bit            pend_w [NR];
  bit            pend_a [NR];
  logic [DW-1:0] pend_d [NR];

  // Reference model state.
  bit            m_wr;      // a write enable is on the datapath this cycle
  int            m_last;    // last granted requester
  int            m_g;       // grant expected this cycle (-1 = none)
  int            cyc = 0;
  logic [NW-1:0] exp_we, exp_re;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] mem_m [NW] = '{'0, '0};
  typedef struct {
    int            due;
    int            tag;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t rq[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pend_v[i];
      req_write[i]           = pend_w[i];
      req_addr[i]            = pend_a[i];
      req_wdata[i*DW +: DW]  = pend_d[i];
    end
  endtask

  task automatic post(input int i, input bit w, input bit a, input logic [DW-1:0] d);
    if (!pend_v[i]) begin
      pend_v[i] = 1'b1;
      pend_w[i] = w;
      pend_a[i] = a;
      pend_d[i] = d;
    end
  endtask

  task automatic model_reset();
    m_wr   = 1'b0;
    m_last = NR - 1;
    m_g    = -1;
    exp_we = '0;
    exp_re = '0;
    exp_wd = '0;
    rq.delete();
  endtask

  // Grant rule: reads never follow a write directly; a waiting read during a
  // write cycle stalls everyone for one cycle; otherwise round-robin.
  function automatic int model_grant();
    if (m_wr) begin
      for (int i = 0; i < NR; i++) begin
        if (pend_v[i] && !pend_w[i]) return -1;
      end
    end
    for (int k = 1; k <= NR; k++) begin
      int c = (m_last + k) % NR;
      if (pend_v[c] && (!m_wr || pend_w[c])) return c;
    end
    return -1;
  endfunction

  task automatic eval();
    logic [NR-1:0] eg;
    logic [NR-1:0] ev;
    drive();
    @(negedge clk);
    m_g = model_grant();
    eg  = '0;
    if (m_g >= 0) eg[m_g] = 1'b1;
    chk("req_ready", req_ready, eg);
    chk("write_enable", write_enable, exp_we);
    chk("read_enable", read_enable, exp_re);
    if (exp_we != '0) chk("write_data", write_data, exp_wd);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev = '0;
      ev[rq[0].tag] = 1'b1;
      chk("rsp_valid", rsp_valid, ev);
      chk("rsp_rdata", rsp_rdata, rq[0].data);
      void'(rq.pop_front());
    end else begin
      chk("rsp_valid_quiet", rsp_valid, '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    exp_we = '0;
    exp_re = '0;
    m_wr   = 1'b0;
    if (m_g >= 0) begin
      if (pend_w[m_g]) begin
        exp_we[pend_a[m_g]] = 1'b1;
        exp_wd              = pend_d[m_g];
        mem_m[pend_a[m_g]]  = pend_d[m_g];
        m_wr                = 1'b1;
      end else begin
        exp_re[pend_a[m_g]] = 1'b1;
        rq.push_back('{due: cyc + 2, tag: m_g, data: mem_m[pend_a[m_g]]});
      end
      m_last       = m_g;
      pend_v[m_g]  = 1'b0;
    end
    m_g = -1;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      eval();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 1'b0;
      pend_w[i] = 1'b0;
      pend_a[i] = 1'b0;
      pend_d[i] = '0;
    end
    model_reset();
    drive();

    // Reset with every requester asserting valid.
    #1 rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend_v[i] = 1'b1;
      pend_w[i] = 1'b0;
      pend_a[i] = i[0];
    end
    drive();
    @(negedge clk);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_write_enable", write_enable, '0);
    chk("rst_read_enable", read_enable, '0);
    chk("rst_write_data", write_data, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    eval();
    chk("rst_first_grant", req_ready, 2'b01);
    tick();
    idle(4);

    // Single write.
    do_reset();
    post(0, 1'b1, 1'b1, 16'hA5A5);
    eval();
    chk("sw_grant_c0", req_ready, 2'b01);
    tick();
    eval();
    chk("sw_we_c1", write_enable, 2'b10);
    chk("sw_wd_c1", write_data, 16'hA5A5);
    tick();
    eval();
    chk("sw_we_c2", write_enable, 2'b00);
    tick();
    idle(2);

    // Write then read of the same word.
    do_reset();
    post(0, 1'b1, 1'b0, 16'h1234);
    post(1, 1'b0, 1'b0, 16'h0000);
    eval();
    chk("wr_grant_c0", req_ready, 2'b01);
    tick();
    eval();
    chk("wr_bubble_c1", req_ready, 2'b00);
    tick();
    eval();
    chk("wr_grant_c2", req_ready, 2'b10);
    tick();
    eval();
    chk("wr_re_c3", read_enable, 2'b01);
    tick();
    eval();
    chk("wr_rsp_valid_c4", rsp_valid, 2'b10);
    chk("wr_rsp_rdata_c4", rsp_rdata, 16'h1234);
    tick();
    idle(2);

    // Fairness: both requesters stream reads.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) post(i, 1'b0, 1'($urandom_range(0, 1)), '0);
      eval();
      chk("fair_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 1) chk("fair_re_busy", |read_enable, 1'b1);
      tick();
    end
    idle(4);

    // Anti-starvation: write stream from req0, read from req1 appears later.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      post(0, 1'b1, 1'($urandom_range(0, 1)), DW'($urandom));
      if (k == 6) post(1, 1'b0, 1'($urandom_range(0, 1)), '0);
      eval();
      if (k < 6)  chk("as_write_stream", req_ready, 2'b01);
      if (k == 6) chk("as_bubble_c6", req_ready, 2'b00);
      if (k == 7) chk("as_read_c7", req_ready, 2'b10);
      if (k == 8) chk("as_resume_c8", req_ready, 2'b01);
      tick();
    end
    idle(4);

    // Reset while a read is in flight.
    do_reset();
    post(0, 1'b0, 1'b1, '0);
    eval();
    chk("rmr_grant_c0", req_ready, 2'b01);
    tick();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("rmr_no_rsp", rsp_valid, '0);
      tick();
    end
    chk("rmr_state_idle", dut.state_q, IDLE);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && $urandom_range(0, 99) < 60)
          post(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
      end
      eval();
      tick();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
